mem_arbiter: RTL

Arbiter and sequencer for the core's single shared word-addressed memory. Two requesters share it: instruction fetch (IF stage) and data load/store (MEM stage). The memory is pipelined with a fixed read latency. The arbiter grants at most one access per cycle, tracks the owner of every in-flight read, and routes each response back to its requester. It also blocks fetches while the core is halted on a SYSTEM instruction.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter and read-owner sequencer for the shared core memory
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   halt                   suppresses new fetch grants
//   if_req/if_addr         fetch request (level-held until if_gnt)
//   if_gnt                 fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata     fetch read response
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request (level-held until d_gnt)
//   d_gnt                  data accepted this cycle (combinational)
//   d_rvalid/d_rdata       load read response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb   memory command, same cycle as grant
//   mem_rdata              memory read data, MEM_LATENCY cycles after a read mem_en
module mem_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                halt,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // last_gnt: port that received the most recent grant (0 = fetch, 1 = data)
  logic last_gnt;
  logic fetch_elig;
  logic data_elig;
  logic grant_if;
  logic grant_d;
  logic read_grant;

  // Owner-tag shift register; index 0 is loaded on the grant edge and
  // index MEM_LATENCY-1 lines up with the cycle mem_rdata is valid.
  logic [MEM_LATENCY-1:0] tag_valid;
  logic [MEM_LATENCY-1:0] tag_owner;

  // Grants are gated by reset_n so nothing is issued while reset is held,
  // even though the reset itself is asynchronous.
  always_comb begin
    fetch_elig = if_req && !halt && reset_n;
    data_elig  = d_req && reset_n;
    // Under contention fetch wins only when data had the previous grant.
    grant_if   = fetch_elig && (!data_elig || (last_gnt == OWNER_D));
    grant_d    = data_elig && !grant_if;
    read_grant = grant_if || (grant_d && !d_we);
  end

  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_en    = grant_if || grant_d;
    mem_we    = grant_d && d_we;
    mem_addr  = grant_d ? d_addr : if_addr;
    mem_wdata = grant_d ? d_wdata : '0;
    mem_wstrb = grant_d ? d_wstrb : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt  <= OWNER_D;
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      if (grant_if || grant_d) begin
        last_gnt <= grant_d ? OWNER_D : OWNER_IF;
      end
      tag_valid[0] <= read_grant;
      tag_owner[0] <= grant_d ? OWNER_D : OWNER_IF;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  always_comb begin
    if_rvalid = tag_valid[MEM_LATENCY-1] && (tag_owner[MEM_LATENCY-1] == OWNER_IF);
    d_rvalid  = tag_valid[MEM_LATENCY-1] && (tag_owner[MEM_LATENCY-1] == OWNER_D);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule
